// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared types, opcodes and mux encodings for the RV32I multicycle controller.
package rv_ctrl_pkg;
   typedef enum logic [3:0] {
      RST, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
      WB_ALU, WB_MEM, BRANCH, JAL, JALR, LUI, TRAP
   } state_t;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
      ALU_SRA, ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE, ALU_GE, ALU_GEU
   } alu_op_t;
   typedef enum logic [1:0] {CLS_R, CLS_I, CLS_BR} alu_cls_t;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
   localparam logic [1:0] WBS_ALUOUT = 2'd0, WBS_MDR = 2'd1, WBS_PC = 2'd2, WBS_IMM = 2'd3;
   localparam logic [1:0] PCS_ALU = 2'd0, PCS_ALUOUT = 2'd1, PCS_JALR = 2'd2;
   localparam logic [1:0] SRCA_PC = 2'd0, SRCA_RS1 = 2'd1, SRCA_OLDPC = 2'd2;
   localparam logic [1:0] SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_4 = 2'd2;

   function automatic state_t dispatch(input logic [6:0] op);
      case (op)
         OP_R:              return EXEC_R;
         OP_IMM, OP_AUIPC:  return EXEC_I;
         OP_LOAD, OP_STORE: return MEM_ADDR;
         OP_BRANCH:         return BRANCH;
         OP_JAL:            return JAL;
         OP_JALR:           return JALR;
         OP_LUI:            return LUI;
         OP_FENCE:          return FETCH;
         default:           return TRAP;
      endcase
   endfunction
endpackage

// File: rtl/rv_multicycle_ctrl_alu_decode.sv
// rv_alu_decode: maps funct3/funct7b5 and the instruction class to an ALU op plus an illegal flag.
module rv_alu_decode
   import rv_ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  alu_cls_t   cls,
   output alu_op_t    alu_ctrl,
   output logic       bad
);
   alu_op_t arith, cmp;
   always_comb begin
      arith = ALU_AND;
      cmp   = ALU_ADD;
      case (funct3)
         3'b000: arith = (cls == CLS_R && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001: arith = ALU_SLL;
         3'b010: arith = ALU_SLT;
         3'b011: arith = ALU_SLTU;
         3'b100: arith = ALU_XOR;
         3'b101: arith = funct7b5 ? ALU_SRA : ALU_SRL;
         3'b110: arith = ALU_OR;
         default: arith = ALU_AND;
      endcase
      case (funct3)
         3'b000: cmp = ALU_EQ;
         3'b001: cmp = ALU_NE;
         3'b100: cmp = ALU_SLT;
         3'b101: cmp = ALU_GE;
         3'b110: cmp = ALU_SLTU;
         3'b111: cmp = ALU_GEU;
         default: cmp = ALU_ADD;
      endcase
      alu_ctrl = (cls == CLS_BR) ? cmp : arith;
      bad = (cls == CLS_BR) ? (funct3[2:1] == 2'b01)
          : (cls == CLS_R && funct7b5 && funct3 != 3'b000 && funct3 != 3'b101);
   end
endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: RV32I multicycle control FSM with memory handshake,
// timeout/illegal trapping and a retired-instruction counter.
module rv_multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic             br_taken,
   input  logic             mem_ready,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             addr_sel,
   output logic             mem_req,
   output logic             mem_we,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       alu_ctrl,
   output logic [2:0]       imm_sel,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] instret
);
   localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   state_t   state_q, state_d;
   logic [TW-1:0] cnt_q;
   alu_cls_t cls;
   alu_op_t  dec_op;
   logic     dec_bad, trap_ill, tmo, retire;

   assign cls = (state_q == BRANCH) ? CLS_BR : (state_q == EXEC_R) ? CLS_R : CLS_I;

   rv_alu_decode u_dec (
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .cls      (cls),
      .alu_ctrl (dec_op),
      .bad      (dec_bad)
   );

   always_comb begin
      state_d   = state_q;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PCS_ALU;
      addr_sel  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      alu_src_a = SRCA_PC;
      alu_src_b = SRCB_RS2;
      alu_ctrl  = ALU_ADD;
      imm_sel   = IMM_I;
      reg_write = 1'b0;
      wb_sel    = WBS_ALUOUT;
      trap_ill  = 1'b0;
      case (state_q)
         RST: state_d = FETCH;
         FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_4;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            state_d   = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_sel   = (opcode == OP_BRANCH) ? IMM_B : IMM_J;
            state_d   = dispatch(opcode);
            trap_ill  = (state_d == TRAP);
         end
         EXEC_R: begin
            alu_src_a = SRCA_RS1;
            alu_ctrl  = dec_op;
            trap_ill  = dec_bad;
            state_d   = dec_bad ? TRAP : WB_ALU;
         end
         EXEC_I: begin
            // AUIPC shares this state: oldPC + U-immediate
            alu_src_a = (opcode == OP_AUIPC) ? SRCA_OLDPC : SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_sel   = (opcode == OP_AUIPC) ? IMM_U : IMM_I;
            alu_ctrl  = (opcode == OP_AUIPC) ? ALU_ADD : dec_op;
            state_d   = WB_ALU;
         end
         WB_ALU: begin
            reg_write = 1'b1;
            state_d   = FETCH;
         end
         MEM_ADDR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
            state_d   = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            state_d  = mem_ready ? WB_MEM : MEM_RD;
         end
         WB_MEM: begin
            reg_write = 1'b1;
            wb_sel    = WBS_MDR;
            state_d   = FETCH;
         end
         MEM_WR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            addr_sel = 1'b1;
            state_d  = mem_ready ? FETCH : MEM_WR;
         end
         BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_ctrl  = dec_op;
            pc_write  = br_taken & ~dec_bad;
            pc_src    = PCS_ALUOUT;
            trap_ill  = dec_bad;
            state_d   = dec_bad ? TRAP : FETCH;
         end
         JAL: begin
            reg_write = 1'b1;
            wb_sel    = WBS_PC;
            pc_write  = 1'b1;
            pc_src    = PCS_ALUOUT;
            state_d   = FETCH;
         end
         JALR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            pc_src    = PCS_JALR;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            wb_sel    = WBS_PC;
            state_d   = FETCH;
         end
         LUI: begin
            reg_write = 1'b1;
            wb_sel    = WBS_IMM;
            imm_sel   = IMM_U;
            state_d   = FETCH;
         end
         default: state_d = TRAP;
      endcase
      // a completing access wins over an expiring timer
      tmo = (MEM_TIMEOUT != 0) && mem_req && !mem_ready && (cnt_q == TW'(MEM_TIMEOUT - 1));
      if (tmo) state_d = TRAP;
      retire = (state_d == FETCH) && (state_q != FETCH) && (state_q != RST);
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= RST;
         cnt_q   <= '0;
         instret <= '0;
         illegal <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= (!mem_req || mem_ready) ? '0 : cnt_q + TW'(1);
         instret <= instret + CNT_W'(retire);
         illegal <= illegal | trap_ill;
         bus_err <= bus_err | tmo;
      end
   end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: directed self-checking bench for rv_multicycle_ctrl (MEM_TIMEOUT=4).
module tb_rv_multicycle_ctrl;
   logic        CLK = 1'b0, Reset = 1'b1;
   logic [6:0]  opcode = '0;
   logic [2:0]  funct3 = '0;
   logic        funct7b5 = 1'b0, br_taken = 1'b0, mem_ready = 1'b0;
   logic        ir_write, pc_write, addr_sel, mem_req, mem_we, reg_write, illegal, bus_err;
   logic [1:0]  pc_src, alu_src_a, alu_src_b, wb_sel;
   logic [3:0]  alu_ctrl;
   logic [2:0]  imm_sel;
   logic [31:0] instret;
   int total = 0, bad = 0;

   rv_multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
      .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .br_taken(br_taken), .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .addr_sel(addr_sel), .mem_req(mem_req), .mem_we(mem_we),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .imm_sel(imm_sel),
      .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err),
      .instret(instret)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge CLK);
      #1;
   endtask

   // present the fields of a fetched word and complete FETCH with zero wait
   task automatic fetch(input logic [31:0] ir);
      opcode = ir[6:0];
      funct3 = ir[14:12];
      funct7b5 = ir[30];
      mem_ready = 1'b1;
      #1;
      check("fetch_irw", {31'd0, ir_write}, 1);
      check("fetch_pcw", {31'd0, pc_write}, 1);
      cyc();
      mem_ready = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      #1;
      cyc();
      Reset = 1'b0;
      #1;
      check("rst_rstate_req", {31'd0, mem_req}, 0);
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc();
      check("reset_req", {31'd0, mem_req}, 0);
      check("reset_instret", instret, 0);
      Reset = 1'b0;
      cyc();
      check("fetch1_req", {31'd0, mem_req}, 1);
      check("fetch1_srcb", {30'd0, alu_src_b}, 2);
      // reset lands mid-fetch
      #2 Reset = 1'b1;
      #1;
      check("midrst_req", {31'd0, mem_req}, 0);
      check("midrst_irw", {31'd0, ir_write}, 0);
      @(negedge CLK);
      Reset = 1'b0;
      #1;
      check("midrst_rst_req", {31'd0, mem_req}, 0);
      cyc();
      check("midrst_fetch_req", {31'd0, mem_req}, 1);
      check("midrst_instret", instret, 0);
      // ADD x10,x10,x11
      fetch(32'h00B50533);
      check("add_dec_a", {30'd0, alu_src_a}, 2);
      check("add_dec_imm", {29'd0, imm_sel}, 4);
      cyc();
      check("add_exec_alu", {28'd0, alu_ctrl}, 0);
      check("add_exec_a", {30'd0, alu_src_a}, 1);
      cyc();
      check("add_wb_rw", {31'd0, reg_write}, 1);
      check("add_wb_sel", {30'd0, wb_sel}, 0);
      cyc();
      check("add_instret", instret, 1);
      // LW x1,0(x2) with three wait cycles in MEM_RD
      fetch(32'h00012083);
      cyc();
      check("lw_addr_imm", {29'd0, imm_sel}, 0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("lw_wait_req", {31'd0, mem_req}, 1);
         check("lw_wait_asel", {31'd0, addr_sel}, 1);
      end
      cyc();
      mem_ready = 1'b1;
      #1;
      check("lw_done_req", {31'd0, mem_req}, 1);
      check("lw_done_asel", {31'd0, addr_sel}, 1);
      cyc();
      mem_ready = 1'b0;
      #1;
      check("lw_wb_sel", {30'd0, wb_sel}, 1);
      check("lw_wb_rw", {31'd0, reg_write}, 1);
      cyc();
      check("lw_instret", instret, 2);
      check("lw_no_buserr", {31'd0, bus_err}, 0);
      // BNE not taken, then taken
      for (int t = 0; t < 2; t++) begin
         fetch(32'h00209463);
         check("bne_dec_imm", {29'd0, imm_sel}, 2);
         cyc();
         br_taken = (t == 1);
         #1;
         check("bne_pcw", {31'd0, pc_write}, t);
         check("bne_pcsrc", {30'd0, pc_src}, 1);
         check("bne_alu", {28'd0, alu_ctrl}, 11);
         cyc();
         br_taken = 1'b0;
         check("bne_instret", instret, 3 + t);
      end
      // LUI x1,0x12345
      fetch(32'h123450B7);
      cyc();
      check("lui_wb_sel", {30'd0, wb_sel}, 3);
      check("lui_imm", {29'd0, imm_sel}, 3);
      check("lui_rw", {31'd0, reg_write}, 1);
      cyc();
      check("lui_instret", instret, 5);
      // SW x2,0(x1) with zero wait
      fetch(32'h0020A023);
      cyc();
      check("sw_addr_imm", {29'd0, imm_sel}, 1);
      cyc();
      mem_ready = 1'b1;
      #1;
      check("sw_we", {31'd0, mem_we}, 1);
      check("sw_asel", {31'd0, addr_sel}, 1);
      cyc();
      mem_ready = 1'b0;
      #1;
      check("sw_instret", instret, 6);
      // illegal opcode 1110011
      fetch(32'h00000073);
      cyc();
      mem_ready = 1'b1;
      #1;
      check("ecall_illegal", {31'd0, illegal}, 1);
      check("ecall_req", {31'd0, mem_req}, 0);
      cyc();
      check("ecall_stay_req", {31'd0, mem_req}, 0);
      check("ecall_stay_pcw", {31'd0, pc_write}, 0);
      check("ecall_instret", instret, 6);
      mem_ready = 1'b0;
      do_reset();
      check("post_rst_illegal", {31'd0, illegal}, 0);
      check("post_rst_instret", instret, 0);
      // SLL with funct7b5 set
      fetch(32'h40B51533);
      cyc();
      cyc();
      check("rbad_illegal", {31'd0, illegal}, 1);
      check("rbad_rw", {31'd0, reg_write}, 0);
      check("rbad_buserr", {31'd0, bus_err}, 0);
      do_reset();
      // fetch never answered: four cycles of request, then trap
      for (int k = 0; k < 4; k++) begin
         check("tmo_req", {31'd0, mem_req}, 1);
         cyc();
      end
      check("tmo_buserr", {31'd0, bus_err}, 1);
      check("tmo_req_off", {31'd0, mem_req}, 0);
      check("tmo_illegal", {31'd0, illegal}, 0);
      do_reset();
      // ready arriving in the fourth cycle completes the fetch
      for (int k = 0; k < 3; k++) cyc();
      mem_ready = 1'b1;
      #1;
      check("tmo_edge_irw", {31'd0, ir_write}, 1);
      cyc();
      mem_ready = 1'b0;
      #1;
      check("tmo_edge_buserr", {31'd0, bus_err}, 0);
      check("tmo_edge_dec_a", {30'd0, alu_src_a}, 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Parametrised multicycle control FSM for the RV32I datapath. It replaces the fixed-wait-state 16-bit-ISA controller. The block decodes RV32I opcode/funct fields, sequences fetch/decode/execute/memory/writeback, and handshakes with memory via `mem_req`/`mem_ready` instead of dummy wait states. It adds a memory timeout, illegal-instruction trapping and a retired-instruction counter. It sits between the instruction register and the datapath muxes, ALU, register file and PC.

## Interface
- `CNT_W`, 32: width of retired-instruction counter.
- `MEM_TIMEOUT`, 15: max cycles `mem_req` may stay high without `mem_ready`; 0 disables the timeout.
- `CLK` in 1: clock, rising edge.
- `Reset` in 1: reset, asynchronous, active-high.
- `opcode` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `funct7b5` in 1: IR[30].
- `br_taken` in 1: comparator result for the current `alu_ctrl` compare.
- `mem_ready` in 1: memory completes the access this cycle.
- `ir_write` out 1: load the IR and the oldPC register.
- `pc_write` out 1: update the PC.
- `pc_src` out 2: 0 = ALU result, 1 = ALUOut, 2 = ALU result & ~1.
- `addr_sel` out 1: memory address; 0 = PC, 1 = ALUOut.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write strobe, valid while `mem_req`.
- `alu_src_a` out 2: 0 = PC, 1 = rs1, 2 = oldPC.
- `alu_src_b` out 2: 0 = rs2, 1 = imm, 2 = const 4.
- `alu_ctrl` out 4: ALU operation (package enum).
- `imm_sel` out 3: immediate format; I, S, B, U, J.
- `reg_write` out 1: register-file write enable.
- `wb_sel` out 2: 0 = ALUOut, 1 = MDR, 2 = PC, 3 = imm.
- `illegal` out 1: sticky flag for an illegal instruction.
- `bus_err` out 1: sticky flag for a memory timeout.
- `instret` out CNT_W: retired-instruction count.

## Operation
**States:** RST, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, JALR, LUI, TRAP.

**Default outputs:** all outputs 0 unless a state below says otherwise. `alu_ctrl` is ADD by default. Outputs are Moore, except the `mem_ready`-qualified strobes.

**RST**
- Outputs all 0.
- Goes to FETCH on the first clock after `Reset` deasserts.

**FETCH**
- `mem_req=1`, `addr_sel=0`, `alu_src_a=0`, `alu_src_b=2`.
- When `mem_ready=1`: `ir_write=1`, `pc_write=1`, `pc_src=0`, then go to DECODE.
- Otherwise hold in FETCH.

**DECODE**
- `alu_src_a=2` and `alu_src_b=1`, so ALUOut gets the branch/JAL target.
- `imm_sel` is B for branch opcodes and J otherwise.
- Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 (AUIPC) → EXEC_I, with `alu_src_a=2`, U immediate, ADD
  - 0001111 (FENCE) → FETCH, counted as retired
  - anything else → TRAP

**EXEC_R**
- `alu_src_a=1`, `alu_src_b=0`.
- `alu_ctrl` comes from funct3/`funct7b5`. `funct7b5=1` is valid only for funct3 000 (SUB) and 101 (SRA); other funct3 values with `funct7b5=1` → TRAP.
- Then → WB_ALU.

**EXEC_I**
- `alu_src_b=1`, `imm_sel=I`.
- `funct7b5` selects SRAI only when funct3=101.
- Then → WB_ALU.

**WB_ALU**
- `reg_write=1`, `wb_sel=0`, then → FETCH.

**MEM_ADDR**
- `alu_src_a=1`, `alu_src_b=1`, `imm_sel` is I for loads and S for stores.
- Loads → MEM_RD; stores → MEM_WR.

**MEM_RD**
- `mem_req=1`, `addr_sel=1`.
- On `mem_ready` → WB_MEM.

**WB_MEM**
- `reg_write=1`, `wb_sel=1`, then → FETCH.

**MEM_WR**
- `mem_req=1`, `mem_we=1`, `addr_sel=1`.
- On `mem_ready` → FETCH.

**BRANCH**
- `alu_src_a=1`, `alu_src_b=0`.
- `alu_ctrl` is the compare op for funct3 (BEQ, BNE, BLT, BGE, BLTU, BGEU).
- `pc_write=br_taken`, `pc_src=1`, then → FETCH.
- funct3 010 or 011 → TRAP.

**JAL**
- `reg_write=1`, `wb_sel=2`, `pc_write=1`, `pc_src=1`, then → FETCH.
- The PC already holds oldPC+4, so the link value is correct.

**JALR**
- `alu_src_a=1`, `alu_src_b=1`, `imm_sel=I`, `pc_src=2`, `pc_write=1`.
- `reg_write=1`, `wb_sel=2` in the same cycle, then → FETCH.

**LUI**
- `reg_write=1`, `wb_sel=3`, `imm_sel=U`, then → FETCH.

**TRAP**
- All strobes 0. Stays in TRAP until `Reset`.
- `illegal` is set when TRAP is entered from decode/execute.
- `bus_err` is set when TRAP is entered on timeout.

**Timeout**
- A counter of width `$clog2(MEM_TIMEOUT+1)` clears whenever `mem_req=0` or `mem_ready=1`, and increments otherwise.
- When it reaches `MEM_TIMEOUT`, go to TRAP at that edge.

**Retirement**
- `instret` increments by 1 on every transition into FETCH from any state except RST.
- It wraps modulo 2^CNT_W.

## Timing
- **Reset:** asynchronous; state = RST and the timeout counter = 0. `instret`, `illegal` and `bus_err` = 0. All outputs are 0 while `Reset` is high, including a reset that lands mid-access: `mem_req` drops combinationally.
- **Instruction latency with zero-wait memory:**
  - LUI, JAL, JALR, BRANCH: 3 cycles.
  - ALU: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- **Handshake:** `mem_req` and `addr_sel` stay stable until the cycle in which `mem_ready=1`. `mem_ready` while `mem_req=0` is ignored.
- **Simultaneous events:** `mem_ready` in the same cycle as timeout expiry counts as completion, not an error.

## Structure
- `rv_ctrl_pkg`: state enum, `alu_ctrl` enum (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, EQ, NE, GE, GEU), opcode constants, and the `imm_sel`, `wb_sel`, `pc_src` and source-mux encodings.
- Sub-module `rv_alu_decode`: combinational mapping of funct3/`funct7b5`/state class to `alu_ctrl` plus an illegal flag.

## Test plan
- **Reset mid-fetch:** assert `Reset` while FETCH holds `mem_req=1` → `mem_req=0` immediately; after release, FETCH is reached in 2 cycles and `instret=0`.
- **Zero-wait ADD (0x00B50533):** → DECODE, EXEC_R, WB_ALU with `alu_ctrl=ADD`, `reg_write=1` in the 4th cycle, `instret=1`.
- **LW with `mem_ready` delayed 3 cycles in MEM_RD:** → `mem_req` held for 4 cycles with `addr_sel=1`, then WB_MEM with `wb_sel=1`; 8 cycles total.
- **BNE with `br_taken=0` then `br_taken=1`:** → `pc_write=0` then `pc_write=1` with `pc_src=1`; both instructions retire.
- **Opcode 1110011 and R-type funct3=001 with `funct7b5=1`:** → TRAP, `illegal=1`, all strobes 0 until `Reset`.
- **`MEM_TIMEOUT=4` with `mem_ready` held low in FETCH:** → TRAP after 4 cycles with `bus_err=1`. A repeat run with `mem_ready` asserted exactly in the 4th cycle completes normally.
